// File: rtl/wave_pkg.sv
// Shared definitions for the waveform display path.
// Contents:
//   SAMPLE_W        width of one waveform sample
//   RAM_AW          waveform RAM address width (one index bit + 8 sample bits)
//   WIN_X, WIN_Y    size of the drawing window in pixels
//   X_SHIFT_DEFAULT log2 of horizontal pixels per sample
//   rgb_t           packed {r, g, b} colour
//   win_hit()       true when a pixel lies inside the drawing window
package wave_pkg;

    localparam int unsigned SAMPLE_W        = 8;
    localparam int unsigned RAM_AW          = 9;
    localparam int          WIN_X           = 1024;
    localparam int          WIN_Y           = 512;
    localparam int unsigned X_SHIFT_DEFAULT = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic win_hit(input logic [10:0] x, input logic [9:0] y);
        return (int'(x) < WIN_X) && (int'(y) < WIN_Y);
    endfunction

endpackage

// File: rtl/wave_display_if.sv
// Pixel stream and waveform RAM read port of wave_display, bundled together.
// Signals:
//   x, y, valid    pixel coordinates and active-video flag from the timing generator
//   read_index     RAM half currently owned by the display
//   read_value     RAM read data, one cycle after read_address
//   read_address   RAM read address
//   valid_pixel    valid aligned with r/g/b
//   r, g, b        pixel colour
// The master modport is the environment (timing generator, RAM, video output);
// the slave modport is the display itself.
interface wave_display_if;
    import wave_pkg::*;

    logic [10:0]         x;
    logic [9:0]          y;
    logic                valid;
    logic                read_index;
    logic [SAMPLE_W-1:0] read_value;
    logic [RAM_AW-1:0]   read_address;
    logic                valid_pixel;
    logic [7:0]          r;
    logic [7:0]          g;
    logic [7:0]          b;

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, valid_pixel, r, g, b
    );

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, valid_pixel, r, g, b
    );

endinterface

// File: rtl/wave_sample_history.sv
// Tracks the current and previous waveform samples as the display walks along a line.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   valid         the pixel in this stage is active video
//   addr          RAM address belonging to this pixel
//   sample        RAM data for addr
//   cur_sample    sample at the end of the segment for this pixel
//   prev_sample   sample at the start of the segment for this pixel
module wave_sample_history
    import wave_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [RAM_AW-1:0]   addr,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] cur_sample,
    output logic [SAMPLE_W-1:0] prev_sample
);

    logic [RAM_AW-1:0]   last_addr_q;
    logic [SAMPLE_W-1:0] cur_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic                addr_change;
    logic                first_col;

    always_comb begin
        addr_change = valid && (addr != last_addr_q);
        // The first sample of a line must not connect to the last one of the previous line.
        first_col   = (addr[RAM_AW-2:0] == '0);
        cur_sample  = sample;
        if (first_col) begin
            prev_sample = sample;
        end else if (addr_change) begin
            // The register update lands on the next edge; bypass it for this pixel.
            prev_sample = cur_q;
        end else begin
            prev_sample = prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr_q <= '1;
            cur_q       <= 8'h80;
            prev_q      <= 8'h80;
        end else if (addr_change) begin
            last_addr_q <= addr;
            cur_q       <= sample;
            prev_q      <= first_col ? sample : cur_q;
        end
    end

endmodule

// File: rtl/wave_display.sv
// Draws the captured waveform as a connected line over the VGA/DVI pixel stream.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           wave_display_if slave: x/y/valid in, RAM read port, r/g/b/valid_pixel out
// Latency from x/y/valid to r/g/b/valid_pixel is two clocks; read_address is combinational.
module wave_display
    import wave_pkg::*;
#(
    parameter int unsigned X_SHIFT = X_SHIFT_DEFAULT,
    parameter rgb_t        FG_RGB  = 24'hFFFFFF,
    parameter rgb_t        BG_RGB  = 24'h000000
) (
    input logic           clk,
    input logic           reset,
    wave_display_if.slave bus
);

    logic [9:0]          x_col;
    logic [RAM_AW-1:0]   addr;

    logic                s1_valid_q;
    logic                s1_in_win_q;
    logic [7:0]          s1_yc_q;
    logic [RAM_AW-1:0]   s1_addr_q;

    logic [SAMPLE_W-1:0] cur_sample;
    logic [SAMPLE_W-1:0] prev_sample;
    logic [SAMPLE_W-1:0] lo;
    logic [SAMPLE_W-1:0] hi;
    logic                lit;

    rgb_t                rgb_q;
    logic                valid_pixel_q;

    // S0: address straight from the incoming column so the RAM data lines up with S1.
    always_comb begin
        x_col = bus.x[9:0];
        addr  = {bus.read_index, (RAM_AW-1)'(x_col >> X_SHIFT)};
    end

    assign bus.read_address = addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_in_win_q <= 1'b0;
            s1_yc_q     <= '0;
            s1_addr_q   <= '0;
        end else begin
            s1_valid_q  <= bus.valid;
            s1_in_win_q <= win_hit(bus.x, bus.y);
            s1_yc_q     <= bus.y[8:1];
            s1_addr_q   <= addr;
        end
    end

    // S1: read_value belongs to s1_addr_q.
    wave_sample_history u_history (
        .clk         (clk),
        .reset       (reset),
        .valid       (s1_valid_q),
        .addr        (s1_addr_q),
        .sample      (bus.read_value),
        .cur_sample  (cur_sample),
        .prev_sample (prev_sample)
    );

    always_comb begin
        lo  = (prev_sample < cur_sample) ? prev_sample : cur_sample;
        hi  = (prev_sample < cur_sample) ? cur_sample : prev_sample;
        lit = s1_valid_q && s1_in_win_q && (s1_yc_q >= lo) && (s1_yc_q <= hi);
    end

    // S2: output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q         <= BG_RGB;
            valid_pixel_q <= 1'b0;
        end else begin
            rgb_q         <= lit ? FG_RGB : BG_RGB;
            valid_pixel_q <= s1_valid_q;
        end
    end

    assign bus.r           = rgb_q.r;
    assign bus.g           = rgb_q.g;
    assign bus.b           = rgb_q.b;
    assign bus.valid_pixel = valid_pixel_q;

endmodule
